// File: rtl/io_dec_pkg.sv
// Shared types, default widths and decode helpers for the I/O window decoder.
package io_dec_pkg;

  localparam int DEF_ADDR_W      = 16;
  localparam int DEF_WIN_BITS    = 8;
  localparam int DEF_NREG        = 64;
  localparam int DEF_WAIT_STATES = 1;
  localparam int DEF_TIMEOUT     = 15;
  localparam int CNT_W           = 8;
  localparam int MAX_ADDR_W      = 32;
  localparam int MAX_REG         = 256;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_STROBE = 3'd2,
    ST_ACK    = 3'd3,
    ST_EXT    = 3'd4
  } io_state_t;

  function automatic logic in_window(input logic [MAX_ADDR_W-1:0] addr,
                                     input logic [MAX_ADDR_W-1:0] base,
                                     input int unsigned win_bits);
    return (addr >> win_bits) == (base >> win_bits);
  endfunction

  // Register exists only when it is below NREG and its mask bit is set.
  function automatic logic impl(input int unsigned idx,
                                input logic [MAX_REG-1:0] mask,
                                input int unsigned nreg);
    logic [MAX_REG-1:0] sh;
    sh = mask >> idx;
    return (idx < nreg) && sh[0];
  endfunction

endpackage

// File: rtl/io_cycle_timer.sv
// 8-bit saturating cycle counter with terminal-count compare against a runtime limit.
module io_cycle_timer
  import io_dec_pkg::*;
(
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             tc
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign tc = (count == limit);

endmodule

// File: rtl/io_window_decoder.sv
// Clocked I/O window decoder: claims in-window bus cycles, inserts wait states,
// issues one-hot register strobes and times out foreign cycles.
//
// state  | meaning
// IDLE   | waiting for req; decode happens here
// WAIT   | counting programmed wait states
// STROBE | single-cycle register strobe or float request
// ACK    | ack held until the master drops req
// EXT    | foreign cycle; wait for ext_ack or time out
module io_window_decoder
  import io_dec_pkg::*;
#(
  parameter int                ADDR_W      = DEF_ADDR_W,
  parameter int                WIN_BITS    = DEF_WIN_BITS,
  parameter logic [ADDR_W-1:0] BASE        = '0,
  parameter int                NREG        = DEF_NREG,
  parameter logic [NREG-1:0]   IMPL_MASK   = '1,
  parameter int                WAIT_STATES = DEF_WAIT_STATES,
  parameter int                TIMEOUT     = DEF_TIMEOUT
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rd,
  input  logic [1:0]        be,
  input  logic              ext_ack,
  output logic              hit,
  output logic [NREG-1:0]   rd_strobe,
  output logic [NREG-1:0]   wr_strobe,
  output logic [1:0]        wr_be,
  output logic              float_en,
  output logic              ack,
  output logic              err
);

  localparam int               IDX_W    = WIN_BITS - 1;
  localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
  localparam logic [CNT_W-1:0] TO_LIM   = CNT_W'(TIMEOUT - 1);
  localparam logic [MAX_REG-1:0] MASK_EXT = MAX_REG'(IMPL_MASK);
  localparam logic [NREG-1:0]  ONE      = NREG'(1);

  io_state_t        state;
  logic [IDX_W-1:0] idx_q;
  logic             rd_q;
  logic [1:0]       be_q;

  logic             win_hit;
  logic             tmr_clr, tmr_en, tmr_tc;
  logic [CNT_W-1:0] tmr_limit;

  logic [IDX_W-1:0] sel_idx;
  logic             sel_rd, sel_impl, fire;
  logic [1:0]       sel_be;
  logic [NREG-1:0]  sel_vec;

  assign win_hit = in_window(MAX_ADDR_W'(addr), MAX_ADDR_W'(BASE), WIN_BITS);

  // With zero wait states the strobe is fired straight from the live bus.
  always_comb begin
    if (state == ST_IDLE) begin
      sel_idx = addr[WIN_BITS-1:1];
      sel_rd  = rd;
      sel_be  = be;
    end else begin
      sel_idx = idx_q;
      sel_rd  = rd_q;
      sel_be  = be_q;
    end
    sel_impl = impl(32'(sel_idx), MASK_EXT, NREG);
    sel_vec  = sel_impl ? (ONE << sel_idx) : '0;
    fire     = ((state == ST_IDLE) && req && win_hit && (WAIT_STATES == 0)) ||
               ((state == ST_WAIT) && req && tmr_tc);
  end

  assign tmr_clr   = (state == ST_IDLE);
  assign tmr_en    = (state == ST_WAIT) || (state == ST_EXT);
  assign tmr_limit = (state == ST_EXT) ? TO_LIM : WAIT_LIM;

  io_cycle_timer u_timer (
    .sys_clk (sys_clk),
    .reset   (reset),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .limit   (tmr_limit),
    .tc      (tmr_tc)
  );

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      idx_q     <= '0;
      rd_q      <= 1'b0;
      be_q      <= 2'b00;
      hit       <= 1'b0;
      rd_strobe <= '0;
      wr_strobe <= '0;
      wr_be     <= 2'b00;
      float_en  <= 1'b0;
      ack       <= 1'b0;
      err       <= 1'b0;
    end else begin
      rd_strobe <= (fire && sel_rd) ? sel_vec : '0;
      wr_strobe <= (fire && !sel_rd) ? sel_vec : '0;
      wr_be     <= (fire && !sel_rd && sel_impl) ? sel_be : 2'b00;
      float_en  <= fire && sel_rd && !sel_impl;
      err       <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            if (win_hit) begin
              idx_q <= addr[WIN_BITS-1:1];
              rd_q  <= rd;
              be_q  <= be;
              hit   <= 1'b1;
              state <= (WAIT_STATES == 0) ? ST_STROBE : ST_WAIT;
            end else begin
              state <= ST_EXT;
            end
          end
        end
        ST_WAIT: begin
          if (!req) begin
            state <= ST_IDLE;
            hit   <= 1'b0;
          end else if (tmr_tc) begin
            state <= ST_STROBE;
          end
        end
        ST_STROBE: begin
          if (req) begin
            state <= ST_ACK;
            ack   <= 1'b1;
          end else begin
            state <= ST_IDLE;
            hit   <= 1'b0;
          end
        end
        ST_ACK: begin
          if (!req) begin
            state <= ST_IDLE;
            ack   <= 1'b0;
            hit   <= 1'b0;
          end
        end
        ST_EXT: begin
          // ext_ack wins over a simultaneous timeout
          if (!req || ext_ack) begin
            state <= ST_IDLE;
          end else if (tmr_tc) begin
            state <= ST_ACK;
            ack   <= 1'b1;
            err   <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          hit   <= 1'b0;
          ack   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_window_decoder.sv
// Scoreboard bench for io_window_decoder: three instances (1, 0 and 3 wait states).
module tb_io_window_decoder;

  typedef struct {
    int          cyc;
    logic [63:0] rs;
    logic [63:0] ws;
    logic [1:0]  be;
    logic        fl;
    logic        ack;
    logic        err;
    logic        hit;
  } ev_t;

  localparam int K_RD = 0, K_WR = 1, K_FLOAT = 2, K_DROP = 3;
  localparam logic [63:0] MASK_M = ~64'h20;

  logic        sys_clk = 1'b0;
  logic        reset;
  logic [15:0] addr;
  logic        rd;
  logic [1:0]  be;
  logic        ext_ack;
  logic        req_m, req_0, req_3;

  logic        hit_m, fl_m, ack_m, err_m;
  logic [63:0] rs_m, ws_m;
  logic [1:0]  wbe_m;
  logic        hit_0, fl_0, ack_0, err_0;
  logic [63:0] rs_0, ws_0;
  logic [1:0]  wbe_0;
  logic        hit_3, fl_3, ack_3, err_3;
  logic [63:0] rs_3, ws_3;
  logic [1:0]  wbe_3;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  ev_t q_m[$];
  ev_t q_0[$];
  ev_t q_3[$];

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  io_window_decoder #(.ADDR_W(16), .WIN_BITS(8), .BASE(16'h0000), .NREG(64),
                      .IMPL_MASK(MASK_M), .WAIT_STATES(1), .TIMEOUT(15)) u_main (
    .sys_clk(sys_clk), .reset(reset), .req(req_m), .addr(addr), .rd(rd), .be(be),
    .ext_ack(ext_ack), .hit(hit_m), .rd_strobe(rs_m), .wr_strobe(ws_m), .wr_be(wbe_m),
    .float_en(fl_m), .ack(ack_m), .err(err_m));

  io_window_decoder #(.ADDR_W(16), .WIN_BITS(8), .BASE(16'h0000), .NREG(64),
                      .IMPL_MASK('1), .WAIT_STATES(0), .TIMEOUT(15)) u_ws0 (
    .sys_clk(sys_clk), .reset(reset), .req(req_0), .addr(addr), .rd(rd), .be(be),
    .ext_ack(ext_ack), .hit(hit_0), .rd_strobe(rs_0), .wr_strobe(ws_0), .wr_be(wbe_0),
    .float_en(fl_0), .ack(ack_0), .err(err_0));

  io_window_decoder #(.ADDR_W(16), .WIN_BITS(8), .BASE(16'h0000), .NREG(64),
                      .IMPL_MASK('1), .WAIT_STATES(3), .TIMEOUT(15)) u_ws3 (
    .sys_clk(sys_clk), .reset(reset), .req(req_3), .addr(addr), .rd(rd), .be(be),
    .ext_ack(ext_ack), .hit(hit_3), .rd_strobe(rs_3), .wr_strobe(ws_3), .wr_be(wbe_3),
    .float_en(fl_3), .ack(ack_3), .err(err_3));

  task automatic push_ev(input int inst, input ev_t e);
    case (inst)
      0:       q_m.push_back(e);
      1:       q_0.push_back(e);
      default: q_3.push_back(e);
    endcase
  endtask

  task automatic push_simple(input int inst, input int c, input logic a, input logic er,
                             input logic h);
    ev_t e;
    e.cyc = c; e.rs = '0; e.ws = '0; e.be = 2'b00; e.fl = 1'b0;
    e.ack = a; e.err = er; e.hit = h;
    push_ev(inst, e);
  endtask

  // In-window cycle decoded at c0 with w wait states and req held for h cycles.
  task automatic exp_inwin(input int inst, input int c0, input int w, input int h,
                           input int kind, input int idx, input logic [1:0] b);
    ev_t e;
    logic [63:0] one_hot;
    one_hot = 64'd1 << idx;
    if (kind != K_DROP) begin
      e.cyc = c0 + 1 + w;
      e.rs  = (kind == K_RD) ? one_hot : 64'd0;
      e.ws  = (kind == K_WR) ? one_hot : 64'd0;
      e.be  = b;
      e.fl  = (kind == K_FLOAT);
      e.ack = 1'b0; e.err = 1'b0; e.hit = 1'b1;
      push_ev(inst, e);
    end
    push_simple(inst, c0 + 2 + w, 1'b1, 1'b0, 1'b1);
    push_simple(inst, c0 + h + 1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_ev(input int inst, input ev_t got, input string name);
    ev_t e;
    int  have;
    logic ok;
    n_checks++;
    case (inst)
      0:       have = q_m.size();
      1:       have = q_0.size();
      default: have = q_3.size();
    endcase
    if (have == 0) begin
      n_fail++;
      $display("FAIL %s unexpected_event cyc=%0d rd=%h wr=%h float=%b ack=%b err=%b hit=%b, required no event",
               name, got.cyc, got.rs, got.ws, got.fl, got.ack, got.err, got.hit);
    end else begin
      case (inst)
        0:       e = q_m.pop_front();
        1:       e = q_0.pop_front();
        default: e = q_3.pop_front();
      endcase
      ok = (e.cyc == got.cyc) && (e.rs === got.rs) && (e.ws === got.ws) &&
           (e.fl === got.fl) && (e.ack === got.ack) && (e.err === got.err) &&
           (e.hit === got.hit) && ((e.ws == 64'd0) || (e.be === got.be));
      if (!ok) begin
        n_fail++;
        $display("FAIL %s event got cyc=%0d rd=%h wr=%h be=%b float=%b ack=%b err=%b hit=%b required cyc=%0d rd=%h wr=%h be=%b float=%b ack=%b err=%b hit=%b",
                 name, got.cyc, got.rs, got.ws, got.be, got.fl, got.ack, got.err, got.hit,
                 e.cyc, e.rs, e.ws, e.be, e.fl, e.ack, e.err, e.hit);
      end
    end
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h required=%h", name, got, exp);
    end
  endtask

  // Monitors: an event is any strobe, float, err, or an ack edge.
  ev_t  g_m, g_0, g_3;
  logic ackp_m = 1'b0, ackp_0 = 1'b0, ackp_3 = 1'b0;

  always @(negedge sys_clk) begin
    if (rs_m != 0 || ws_m != 0 || fl_m || err_m || ack_m != ackp_m) begin
      g_m.cyc = cyc; g_m.rs = rs_m; g_m.ws = ws_m; g_m.be = wbe_m; g_m.fl = fl_m;
      g_m.ack = ack_m; g_m.err = err_m; g_m.hit = hit_m;
      check_ev(0, g_m, "main");
    end
    ackp_m = ack_m;
  end

  always @(negedge sys_clk) begin
    if (rs_0 != 0 || ws_0 != 0 || fl_0 || err_0 || ack_0 != ackp_0) begin
      g_0.cyc = cyc; g_0.rs = rs_0; g_0.ws = ws_0; g_0.be = wbe_0; g_0.fl = fl_0;
      g_0.ack = ack_0; g_0.err = err_0; g_0.hit = hit_0;
      check_ev(1, g_0, "ws0");
    end
    ackp_0 = ack_0;
  end

  always @(negedge sys_clk) begin
    if (rs_3 != 0 || ws_3 != 0 || fl_3 || err_3 || ack_3 != ackp_3) begin
      g_3.cyc = cyc; g_3.rs = rs_3; g_3.ws = ws_3; g_3.be = wbe_3; g_3.fl = fl_3;
      g_3.ack = ack_3; g_3.err = err_3; g_3.hit = hit_3;
      check_ev(2, g_3, "ws3");
    end
    ackp_3 = ack_3;
  end

  task automatic wait_to(input int c);
    while (cyc < c) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic set_req(input int inst, input logic v);
    case (inst)
      0:       req_m = v;
      1:       req_0 = v;
      default: req_3 = v;
    endcase
  endtask

  task automatic start_req(input int inst, input logic [15:0] a, input logic r,
                           input logic [1:0] b, output int c0);
    addr = a; rd = r; be = b;
    set_req(inst, 1'b1);
    c0 = cyc;
  endtask

  initial begin
    int c0, c1;
    reset = 1'b1; addr = '0; rd = 1'b0; be = 2'b00; ext_ack = 1'b0;
    req_m = 1'b0; req_0 = 1'b0; req_3 = 1'b0;
    #2;
    chk("reset_ctrl_main", {59'd0, hit_m, fl_m, ack_m, err_m, 1'b0} | {62'd0, wbe_m}, 64'd0);
    chk("reset_rd_strobe", rs_m, 64'd0);
    chk("reset_wr_strobe", ws_m, 64'd0);
    chk("reset_ctrl_others", {56'd0, hit_0, ack_0, err_0, fl_0, hit_3, ack_3, err_3, fl_3}, 64'd0);
    repeat (3) @(posedge sys_clk);
    #1 reset = 1'b0;
    @(posedge sys_clk); #1;

    // read idx 2, req held 5 cycles
    start_req(0, 16'h0004, 1'b1, 2'b11, c0);
    exp_inwin(0, c0, 1, 5, K_RD, 2, 2'b00);
    wait_to(c0 + 5); req_m = 1'b0;
    wait_to(c0 + 8);

    // zero-wait write idx 35, upper byte lane
    start_req(1, 16'h0046, 1'b0, 2'b10, c0);
    exp_inwin(1, c0, 0, 3, K_WR, 35, 2'b10);
    wait_to(c0 + 3); req_0 = 1'b0;
    wait_to(c0 + 6);

    // unimplemented register 5: float on read, dropped write
    start_req(0, 16'h000A, 1'b1, 2'b11, c0);
    exp_inwin(0, c0, 1, 4, K_FLOAT, 5, 2'b00);
    wait_to(c0 + 4); req_m = 1'b0;
    wait_to(c0 + 7);
    start_req(0, 16'h000A, 1'b0, 2'b11, c0);
    exp_inwin(0, c0, 1, 4, K_DROP, 5, 2'b00);
    wait_to(c0 + 4); req_m = 1'b0;
    wait_to(c0 + 7);

    // foreign cycle times out
    start_req(0, 16'h0200, 1'b1, 2'b11, c0);
    push_simple(0, c0 + 16, 1'b1, 1'b1, 1'b0);
    push_simple(0, c0 + 19, 1'b0, 1'b0, 1'b0);
    wait_to(c0 + 18); req_m = 1'b0;
    wait_to(c0 + 21);

    // foreign cycle completed by ext_ack
    start_req(0, 16'h0200, 1'b1, 2'b11, c0);
    wait_to(c0 + 5); ext_ack = 1'b1;
    wait_to(c0 + 6); ext_ack = 1'b0; req_m = 1'b0;
    chk("ext_ack_no_ack", {62'd0, ack_m, err_m}, 64'd0);
    wait_to(c0 + 9);

    // ext_ack in the timeout cycle suppresses err
    start_req(0, 16'h0200, 1'b1, 2'b11, c0);
    wait_to(c0 + 15); ext_ack = 1'b1;
    wait_to(c0 + 16); ext_ack = 1'b0; req_m = 1'b0;
    chk("tie_no_ack_err", {62'd0, ack_m, err_m}, 64'd0);
    wait_to(c0 + 19);

    // three wait states: abort in WAIT, then a normal read idx 4
    start_req(2, 16'h0004, 1'b1, 2'b11, c0);
    wait_to(c0 + 2); req_3 = 1'b0;
    wait_to(c0 + 3);
    chk("abort_hit_clear", {63'd0, hit_3}, 64'd0);
    wait_to(c0 + 8);
    start_req(2, 16'h0008, 1'b1, 2'b11, c0);
    exp_inwin(2, c0, 3, 6, K_RD, 4, 2'b00);
    wait_to(c0 + 6); req_3 = 1'b0;
    wait_to(c0 + 10);

    // async reset during the strobe cycle
    start_req(0, 16'h0004, 1'b1, 2'b11, c0);
    wait_to(c0 + 2);
    chk("pre_reset_strobe", rs_m, 64'h4);
    #1 reset = 1'b1;
    #1;
    chk("mid_reset_strobe", rs_m, 64'd0);
    chk("mid_reset_ctrl", {62'd0, hit_m, ack_m}, 64'd0);
    req_m = 1'b0;
    @(posedge sys_clk); #1;
    @(posedge sys_clk); #1;
    reset = 1'b0;
    @(posedge sys_clk); #1;

    // back-to-back reads idx 0 and 1, req low one cycle between
    start_req(0, 16'h0000, 1'b1, 2'b11, c0);
    exp_inwin(0, c0, 1, 4, K_RD, 0, 2'b00);
    wait_to(c0 + 4); req_m = 1'b0;
    wait_to(c0 + 5);
    start_req(0, 16'h0002, 1'b1, 2'b11, c1);
    exp_inwin(0, c1, 1, 4, K_RD, 1, 2'b00);
    wait_to(c1 + 4); req_m = 1'b0;
    wait_to(c1 + 8);

    chk("pending_main", 64'(q_m.size()), 64'd0);
    chk("pending_ws0", 64'(q_0.size()), 64'd0);
    chk("pending_ws3", 64'(q_3.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
